// File: rtl/interboard_link_if.sv
// Signal bundle for one interboard_link_ctrl instance: the message-side
// handshake towards game control and the Request/Ack/data pins towards the
// peer board. The link controller takes the slave view and its environment
// takes the master view.
interface interboard_link_if #(
    parameter int DATA_W    = 6,
    parameter int MSG_WORDS = 4
);
    // Message side
    logic                          tx_valid;
    logic [DATA_W*MSG_WORDS-1:0]   tx_msg;
    logic                          tx_ready;
    logic                          tx_done;
    logic                          tx_timeout;
    logic                          rx_valid;
    logic [DATA_W*MSG_WORDS-1:0]   rx_msg;
    logic                          rx_err;

    // Board pins
    logic                          Request_in;
    logic                          Ack_in;
    logic [DATA_W-1:0]             inter_data_in;
    logic                          Request_out;
    logic                          Ack_out;
    logic [DATA_W-1:0]             inter_data_out;

    modport slave (
        input  tx_valid, tx_msg, Request_in, Ack_in, inter_data_in,
        output tx_ready, tx_done, tx_timeout, rx_valid, rx_msg, rx_err,
               Request_out, Ack_out, inter_data_out
    );

    modport master (
        output tx_valid, tx_msg, Request_in, Ack_in, inter_data_in,
        input  tx_ready, tx_done, tx_timeout, rx_valid, rx_msg, rx_err,
               Request_out, Ack_out, inter_data_out
    );
endinterface

// File: rtl/interboard_link_ctrl.sv
// Full-duplex Request/Ack word transceiver between two player boards.
// A message of MSG_WORDS words (word 0 = least-significant slice) is sent
// one four-phase handshake per word. TX and RX run as independent FSMs,
// each with its own handshake timeout. Every output is a flop.
module interboard_link_ctrl #(
    parameter int DATA_W      = 6,
    parameter int MSG_WORDS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic              clk,
    input logic              rst,
    interboard_link_if.slave lnk
);

    localparam int MSG_W = DATA_W * MSG_WORDS;
    localparam int IDX_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        T_IDLE,
        T_SETUP,
        T_REQ,
        T_REL
    } tx_state_t;

    typedef enum logic {
        R_IDLE,
        R_HOLD
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (data is not synchronised: it is stable for a
    // full cycle before Request rises and while it is held).
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   req_s;
    logic                   ack_s;

    // Shift the asynchronous Request/Ack through SYNC_STAGES flops.
    // NOTE: sequential state uses <= so every flop samples the pre-edge
    // value of its neighbour; blocking = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_sync <= '0;
            ack_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], lnk.Request_in};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], lnk.Ack_in};
        end
    end

    assign req_s = req_sync[SYNC_STAGES-1];
    assign ack_s = ack_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t                        tx_state,     tx_state_n;
    logic [IDX_W-1:0]                 tx_idx,       tx_idx_n;
    logic [CNT_W-1:0]                 tx_cnt,       tx_cnt_n;
    logic                             tx_ready_q,   tx_ready_n;
    logic                             tx_done_q,    tx_done_n;
    logic                             tx_timeout_q, tx_timeout_n;
    logic                             req_out_q,    req_out_n;
    logic [DATA_W-1:0]                data_out_q,   data_out_n;
    logic                             tx_load;
    logic [MSG_WORDS-1:0][DATA_W-1:0] tx_buf;

    // TX next-state, next-output and timeout counter logic.
    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned; that is what keeps this block latch-free.
    always_comb begin
        tx_state_n   = tx_state;
        tx_idx_n     = tx_idx;
        tx_done_n    = 1'b0;
        tx_timeout_n = 1'b0;
        req_out_n    = req_out_q;
        data_out_n   = data_out_q;
        tx_load      = 1'b0;

        case (tx_state)
            T_IDLE: begin
                req_out_n = 1'b0;
                if (lnk.tx_valid && tx_ready_q) begin
                    tx_load    = 1'b1;
                    tx_idx_n   = '0;
                    tx_state_n = T_SETUP;
                end
            end
            T_SETUP: begin
                // Present the word a full cycle before Request rises.
                req_out_n  = 1'b0;
                data_out_n = tx_buf[tx_idx];
                tx_state_n = T_REQ;
            end
            T_REQ: begin
                if (ack_s) begin
                    req_out_n  = 1'b0;
                    tx_state_n = T_REL;
                end else if (tx_cnt == CNT_LIM) begin
                    req_out_n    = 1'b0;
                    tx_idx_n     = '0;
                    tx_timeout_n = 1'b1;
                    tx_state_n   = T_IDLE;
                end else begin
                    req_out_n = 1'b1;
                end
            end
            T_REL: begin
                if (!ack_s) begin
                    if (tx_idx == LAST_IDX) begin
                        tx_idx_n   = '0;
                        tx_done_n  = 1'b1;
                        tx_state_n = T_IDLE;
                    end else begin
                        tx_idx_n   = tx_idx + IDX_W'(1);
                        tx_state_n = T_SETUP;
                    end
                end else if (tx_cnt == CNT_LIM) begin
                    req_out_n    = 1'b0;
                    tx_idx_n     = '0;
                    tx_timeout_n = 1'b1;
                    tx_state_n   = T_IDLE;
                end
            end
            default: tx_state_n = T_IDLE;
        endcase

        // Ready is asserted on the very edge the FSM lands back in idle.
        tx_ready_n = (tx_state_n == T_IDLE);

        // Completion has already been given priority above, so a count at
        // the limit only matters when the handshake did not advance.
        if (tx_state_n != tx_state) begin
            tx_cnt_n = '0;
        end else if (tx_state == T_REQ || tx_state == T_REL) begin
            tx_cnt_n = (tx_cnt == CNT_LIM) ? tx_cnt : tx_cnt + CNT_W'(1);
        end else begin
            tx_cnt_n = '0;
        end
    end

    // TX state and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state     <= T_IDLE;
            tx_idx       <= '0;
            tx_cnt       <= '0;
            tx_ready_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
            req_out_q    <= 1'b0;
            data_out_q   <= '0;
        end else begin
            tx_state     <= tx_state_n;
            tx_idx       <= tx_idx_n;
            tx_cnt       <= tx_cnt_n;
            tx_ready_q   <= tx_ready_n;
            tx_done_q    <= tx_done_n;
            tx_timeout_q <= tx_timeout_n;
            req_out_q    <= req_out_n;
            data_out_q   <= data_out_n;
        end
    end

    // Capture the outgoing message when it is accepted.
    // NOTE: payload storage has no reset; it is always written before it
    // is read, and leaving it out keeps reset fan-out off the data path.
    always_ff @(posedge clk) begin
        if (tx_load) begin
            tx_buf <= lnk.tx_msg;
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_t                        rx_state,   rx_state_n;
    logic [IDX_W-1:0]                 rx_idx,     rx_idx_n;
    logic [CNT_W-1:0]                 rx_cnt,     rx_cnt_n;
    logic                             ack_out_q,  ack_out_n;
    logic                             rx_valid_q, rx_valid_n;
    logic                             rx_err_q,   rx_err_n;
    logic [MSG_W-1:0]                 rx_msg_q,   rx_msg_n;
    logic                             slot_we;
    logic [MSG_WORDS-1:0][DATA_W-1:0] slots;

    // RX next-state, next-output and timeout counter logic.
    always_comb begin
        rx_state_n = rx_state;
        rx_idx_n   = rx_idx;
        ack_out_n  = ack_out_q;
        rx_valid_n = 1'b0;
        rx_err_n   = 1'b0;
        rx_msg_n   = rx_msg_q;
        slot_we    = 1'b0;

        case (rx_state)
            R_IDLE: begin
                ack_out_n = 1'b0;
                if (req_s) begin
                    slot_we    = 1'b1;
                    ack_out_n  = 1'b1;
                    rx_state_n = R_HOLD;
                end else if (rx_idx != '0 && rx_cnt == CNT_LIM) begin
                    // Peer went quiet between words: drop the partial message.
                    rx_idx_n = '0;
                    rx_err_n = 1'b1;
                end
            end
            R_HOLD: begin
                if (!req_s) begin
                    ack_out_n  = 1'b0;
                    rx_state_n = R_IDLE;
                    if (rx_idx == LAST_IDX) begin
                        rx_msg_n   = slots;
                        rx_valid_n = 1'b1;
                        rx_idx_n   = '0;
                    end else begin
                        rx_idx_n = rx_idx + IDX_W'(1);
                    end
                end else if (rx_cnt == CNT_LIM) begin
                    ack_out_n  = 1'b0;
                    rx_idx_n   = '0;
                    rx_err_n   = 1'b1;
                    rx_state_n = R_IDLE;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase

        if (rx_state_n != rx_state) begin
            rx_cnt_n = '0;
        end else if (rx_state == R_HOLD || rx_idx != '0) begin
            rx_cnt_n = (rx_cnt == CNT_LIM) ? rx_cnt : rx_cnt + CNT_W'(1);
        end else begin
            rx_cnt_n = '0;
        end
    end

    // RX state and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            rx_idx     <= '0;
            rx_cnt     <= '0;
            ack_out_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_msg_q   <= '0;
        end else begin
            rx_state   <= rx_state_n;
            rx_idx     <= rx_idx_n;
            rx_cnt     <= rx_cnt_n;
            ack_out_q  <= ack_out_n;
            rx_valid_q <= rx_valid_n;
            rx_err_q   <= rx_err_n;
            rx_msg_q   <= rx_msg_n;
        end
    end

    // Assemble incoming words into their slot as each request is seen.
    always_ff @(posedge clk) begin
        if (slot_we) begin
            slots[rx_idx] <= lnk.inter_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lnk.tx_ready       = tx_ready_q;
    assign lnk.tx_done        = tx_done_q;
    assign lnk.tx_timeout     = tx_timeout_q;
    assign lnk.Request_out    = req_out_q;
    assign lnk.inter_data_out = data_out_q;
    assign lnk.Ack_out        = ack_out_q;
    assign lnk.rx_valid       = rx_valid_q;
    assign lnk.rx_err         = rx_err_q;
    assign lnk.rx_msg         = rx_msg_q;

endmodule

// File: tb/tb_interboard_link_ctrl.sv
// Two link controllers wired back to back (A <-> B), with a switch that
// lets the bench play the peer itself for the timeout and partial-message
// cases. Expected messages are queued per receiver when stimulus is driven
// and compared when that receiver pulses rx_valid.
module tb_interboard_link_ctrl;

    localparam int DW    = 6;
    localparam int MW    = 3;
    localparam int SS    = 2;
    localparam int TO    = 64;
    localparam int MSG_W = DW * MW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    interboard_link_if #(.DATA_W(DW), .MSG_WORDS(MW)) a_if ();
    interboard_link_if #(.DATA_W(DW), .MSG_WORDS(MW)) b_if ();

    interboard_link_ctrl #(
        .DATA_W(DW), .MSG_WORDS(MW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .lnk (a_if)
    );

    interboard_link_ctrl #(
        .DATA_W(DW), .MSG_WORDS(MW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .lnk (b_if)
    );

    // Link wiring: loopback, or bench-driven peer pins when loop==0.
    logic          loop       = 1'b1;
    logic          a_ack_drv  = 1'b0;
    logic          b_req_drv  = 1'b0;
    logic [DW-1:0] b_data_drv = '0;

    assign a_if.Request_in    = loop ? b_if.Request_out : 1'b0;
    assign a_if.Ack_in        = loop ? b_if.Ack_out     : a_ack_drv;
    assign a_if.inter_data_in = b_if.inter_data_out;
    assign b_if.Request_in    = loop ? a_if.Request_out    : b_req_drv;
    assign b_if.Ack_in        = loop ? a_if.Ack_out        : 1'b0;
    assign b_if.inter_data_in = loop ? a_if.inter_data_out : b_data_drv;

    int n_vec = 0;
    int n_err = 0;

    logic [MSG_W-1:0] exp_a[$];
    logic [MSG_W-1:0] exp_b[$];

    int a_rx = 0, b_rx = 0, a_done = 0, b_done = 0;
    int a_to = 0, b_to = 0, a_err = 0, b_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_if.rx_valid) begin
            a_rx++;
            if (exp_a.size() == 0) check("a_rx_unexpected", 32'(a_if.rx_msg), 32'hFFFF_FFFF);
            else check("a_rx_msg", 32'(a_if.rx_msg), 32'(exp_a.pop_front()));
        end
        if (b_if.rx_valid) begin
            b_rx++;
            if (exp_b.size() == 0) check("b_rx_unexpected", 32'(b_if.rx_msg), 32'hFFFF_FFFF);
            else check("b_rx_msg", 32'(b_if.rx_msg), 32'(exp_b.pop_front()));
        end
        if (a_if.tx_done)    a_done++;
        if (b_if.tx_done)    b_done++;
        if (a_if.tx_timeout) a_to++;
        if (b_if.tx_timeout) b_to++;
        if (a_if.rx_err)     a_err++;
        if (b_if.rx_err)     b_err++;
    end

    // Offer one message on either or both sides in the same cycle.
    task automatic offer(input bit va, input logic [MSG_W-1:0] ma,
                         input bit vb, input logic [MSG_W-1:0] mb, input bit expect_rx);
        if (va) begin
            check("a_ready_before_offer", 32'(a_if.tx_ready), 32'd1);
            a_if.tx_valid = 1'b1;
            a_if.tx_msg   = ma;
            if (expect_rx) exp_b.push_back(ma);
        end
        if (vb) begin
            check("b_ready_before_offer", 32'(b_if.tx_ready), 32'd1);
            b_if.tx_valid = 1'b1;
            b_if.tx_msg   = mb;
            if (expect_rx) exp_a.push_back(mb);
        end
        @(posedge clk);
        #1;
        a_if.tx_valid = 1'b0;
        b_if.tx_valid = 1'b0;
    endtask

    // Wait, bounded, until both transmitters are idle and the scoreboard drained.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < 1000 && !(exp_a.size() == 0 && exp_b.size() == 0 &&
                             a_if.tx_ready && b_if.tx_ready)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n < 1000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Bench acting as the peer transmitter towards B for one word.
    task automatic peer_word(input logic [DW-1:0] w);
        int n;
        b_data_drv = w;
        b_req_drv  = 1'b1;
        n = 0;
        while (!b_if.Ack_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("peer_ack_rise", 32'(b_if.Ack_out), 32'd1);
        b_req_drv = 1'b0;
        n = 0;
        while (b_if.Ack_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("peer_ack_fall", 32'(b_if.Ack_out), 32'd0);
    endtask

    initial begin
        logic [MSG_W-1:0] msg;
        logic [MSG_W-1:0] mb;
        int d0, d1, r0, r1, e0, t0, n;

        a_if.tx_valid = 1'b0;
        a_if.tx_msg   = '0;
        b_if.tx_valid = 1'b0;
        b_if.tx_msg   = '0;

        // Reset held for three edges: every output low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ctrl", 32'({a_if.tx_ready, a_if.tx_done, a_if.tx_timeout, a_if.Request_out,
                                 a_if.Ack_out, a_if.rx_valid, a_if.rx_err}), 32'd0);
        check("rst_a_data", 32'(a_if.inter_data_out), 32'd0);
        check("rst_a_rx_msg", 32'(a_if.rx_msg), 32'd0);
        check("rst_b_ctrl", 32'({b_if.tx_ready, b_if.tx_done, b_if.tx_timeout, b_if.Request_out,
                                 b_if.Ack_out, b_if.rx_valid, b_if.rx_err}), 32'd0);
        check("rst_b_data", 32'(b_if.inter_data_out), 32'd0);
        check("rst_b_rx_msg", 32'(b_if.rx_msg), 32'd0);
        rst = 1'b1;
        check("rel_ready_not_yet", 32'(a_if.tx_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_a_ready", 32'(a_if.tx_ready), 32'd1);
        check("rel_b_ready", 32'(b_if.tx_ready), 32'd1);

        // A -> B single message, with accept/setup/request latency.
        msg = 18'h2A5C3;
        d0 = a_done; r0 = b_rx; e0 = a_err + b_err + a_to + b_to;
        a_if.tx_valid = 1'b1;
        a_if.tx_msg   = msg;
        exp_b.push_back(msg);
        @(posedge clk);
        #1;
        a_if.tx_valid = 1'b0;
        check("acc_ready_low", 32'(a_if.tx_ready), 32'd0);
        @(posedge clk);
        #1;
        check("setup_data_word0", 32'(a_if.inter_data_out), 32'(msg[DW-1:0]));
        check("setup_req_low", 32'(a_if.Request_out), 32'd0);
        @(posedge clk);
        #1;
        check("req_high", 32'(a_if.Request_out), 32'd1);
        wait_idle("single_complete");
        check("single_b_rx_count", 32'(b_rx - r0), 32'd1);
        check("single_a_done_count", 32'(a_done - d0), 32'd1);
        check("single_a_ready", 32'(a_if.tx_ready), 32'd1);
        check("single_no_err", 32'(a_err + b_err + a_to + b_to - e0), 32'd0);

        // Simultaneous A -> B and B -> A.
        d0 = a_done; d1 = b_done; r0 = a_rx; r1 = b_rx;
        offer(1'b1, 18'h00FFF, 1'b1, 18'h3F001, 1'b1);
        wait_idle("duplex_complete");
        check("duplex_a_rx_count", 32'(a_rx - r0), 32'd1);
        check("duplex_b_rx_count", 32'(b_rx - r1), 32'd1);
        check("duplex_done_count", 32'(a_done - d0 + b_done - d1), 32'd2);
        check("duplex_no_err", 32'(a_err + b_err + a_to + b_to - e0), 32'd0);

        // A few random duplex messages.
        r0 = a_rx; r1 = b_rx;
        for (int i = 0; i < 4; i++) begin
            msg = MSG_W'($urandom);
            mb  = MSG_W'($urandom);
            offer(1'b1, msg, 1'b1, mb, 1'b1);
            wait_idle("rand_complete");
        end
        check("rand_rx_count", 32'(a_rx - r0 + b_rx - r1), 32'd8);

        // TX timeout: peer never acknowledges.
        loop = 1'b0;
        a_ack_drv = 1'b0;
        t0 = a_to; d0 = a_done;
        offer(1'b1, 18'h12345, 1'b0, '0, 1'b0);
        n = 0;
        while (!a_if.Request_out && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("to_req_rise", 32'(a_if.Request_out), 32'd1);
        n = 0;
        while (!a_if.tx_timeout && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("to_latency", 32'(n), 32'd64);
        check("to_req_low", 32'(a_if.Request_out), 32'd0);
        check("to_ready", 32'(a_if.tx_ready), 32'd1);
        @(posedge clk);
        #1;
        check("to_pulse_width", 32'(a_if.tx_timeout), 32'd0);
        check("to_count", 32'(a_to - t0), 32'd1);
        check("to_no_done", 32'(a_done - d0), 32'd0);

        // Partial message into B, then silence.
        r1 = b_rx; e0 = b_err;
        peer_word(6'h15);
        peer_word(6'h2A);
        n = 0;
        while (!b_if.rx_err && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rxerr_latency", 32'(n), 32'd65);
        repeat (2) @(posedge clk);
        #1;
        check("rxerr_count", 32'(b_err - e0), 32'd1);
        check("rxerr_no_valid", 32'(b_rx - r1), 32'd0);

        // Following full message is assembled from a clean start.
        exp_b.push_back({6'h3E, 6'h2B, 6'h11});
        peer_word(6'h11);
        peer_word(6'h2B);
        peer_word(6'h3E);
        repeat (3) @(posedge clk);
        #1;
        check("rx_after_err_count", 32'(b_rx - r1), 32'd1);
        check("rx_after_err_drained", 32'(exp_b.size()), 32'd0);
        check("rx_after_err_no_err", 32'(b_err - e0), 32'd1);

        // Reset while A holds Request_out high.
        d0 = a_done; t0 = a_to;
        offer(1'b1, 18'h0ABCD, 1'b0, '0, 1'b0);
        n = 0;
        while (!a_if.Request_out && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_req_rise", 32'(a_if.Request_out), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_req_dropped", 32'(a_if.Request_out), 32'd0);
        check("mid_ready_low", 32'(a_if.tx_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ready_back", 32'(a_if.tx_ready), 32'd1);
        check("mid_no_pulses", 32'(a_done - d0 + a_to - t0), 32'd0);

        // Link still works end to end after the reset.
        loop = 1'b1;
        r1 = b_rx;
        offer(1'b1, 18'h3C3C3, 1'b0, '0, 1'b1);
        wait_idle("post_reset_complete");
        check("post_reset_rx_count", 32'(b_rx - r1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute backstop in case a bounded loop is ever bypassed.
    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interboard_link_ctrl.md
Name: interboard_link_ctrl

Overview:
- Parametrised full-duplex transceiver for the two-board Request/Ack/data link used between player boards.
- Generalises the fixed 6-bit single-word exchange to DATA_W-bit words and MSG_WORDS-word messages.
- Adds input synchronisation, per-handshake timeout and partial-message discard.
- Sits between game control/memory handling and the board pins. TX and RX paths run independently.

Parameters:
- DATA_W, 6: link data width in bits (inter_data_in/out).
- MSG_WORDS, 4: words per message, must be ≥1. Word 0 is the least-significant slice.
- SYNC_STAGES, 2: flip-flop stages on Request_in and Ack_in, must be ≥2.
- TIMEOUT_CYC, 1000: maximum cycles spent waiting in any handshake phase.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-low.
- tx_valid, input, 1: message offered for sending.
- tx_msg, input, DATA_W*MSG_WORDS: message payload, captured on accept.
- tx_ready, output, 1: TX idle, can accept a message.
- tx_done, output, 1: one-cycle pulse, message fully sent.
- tx_timeout, output, 1: one-cycle pulse, TX handshake aborted.
- Request_in, input, 1: asynchronous request from the peer.
- Ack_in, input, 1: asynchronous acknowledge from the peer.
- inter_data_in, input, DATA_W: data from the peer.
- Request_out, output, 1: request to the peer.
- Ack_out, output, 1: acknowledge to the peer.
- inter_data_out, output, DATA_W: data to the peer.
- rx_valid, output, 1: one-cycle pulse, rx_msg holds a new message.
- rx_msg, output, DATA_W*MSG_WORDS: last complete received message.
- rx_err, output, 1: one-cycle pulse, partial message discarded.

Behaviour:
- Reset (rst==0 at a clk edge): all outputs 0, including tx_ready. Both FSMs go idle, word indices 0, timeout counters 0, synchronisers cleared. tx_ready rises on the first edge after rst returns to 1.
- Reset mid-transfer aborts immediately. Request_out/Ack_out drop with no pulses issued.
- Synchronisers: req_s and ack_s are Request_in and Ack_in delayed by SYNC_STAGES flops. inter_data_in is not synchronised.
- All outputs are registered.
- TX FSM:
  - T_IDLE: tx_ready=1. On tx_valid&&tx_ready at edge T, latch tx_msg, set word index 0, tx_ready=0. Go to T_SETUP.
  - T_SETUP: inter_data_out=word[idx] from edge T+1. Request_out=0. Lasts exactly one cycle, then T_REQ.
  - T_REQ: Request_out=1 from edge T+2. Wait for ack_s==1, then Request_out=0 and go to T_REL.
  - T_REL: wait for ack_s==0.
    - If idx==MSG_WORDS-1: tx_done=1 for one cycle, go to T_IDLE, tx_ready=1 on the same edge.
    - Otherwise idx+1 and go to T_SETUP.
  - inter_data_out holds its value from T_SETUP until the next T_SETUP.
  - tx_valid while tx_ready==0 is ignored.
- RX FSM:
  - R_IDLE, Ack_out=0: when req_s==1, capture inter_data_in into slot idx, Ack_out=1, go to R_HOLD.
  - R_HOLD: when req_s==0, Ack_out=0.
    - If idx==MSG_WORDS-1: update rx_msg from the assembled slots with the new word, rx_valid=1 on the same edge, idx=0.
    - Otherwise idx+1. Either way return to R_IDLE.
  - rx_msg holds its value between rx_valid pulses.
- Timeouts:
  - A per-FSM counter clears on every state change and increments while in T_REQ, T_REL, R_HOLD, or R_IDLE with idx≠0.
  - Counter reaching TIMEOUT_CYC in T_REQ/T_REL: Request_out=0, idx=0, tx_timeout pulse, go to T_IDLE. The message is dropped, no retry.
  - Counter reaching TIMEOUT_CYC in R_IDLE with idx≠0: idx=0, rx_err pulse. In R_HOLD: Ack_out=0, idx=0, rx_err pulse, go to R_IDLE.
  - Counter width is $clog2(TIMEOUT_CYC+1). It never wraps.
- Simultaneous events:
  - The TX and RX FSMs are fully independent; concurrent send and receive is legal.
  - When the timeout limit and handshake completion fall on the same edge, completion wins.
- MSG_WORDS==1: every handshake completes a message.

Test Plan:
- Loopback of two instances (A.out→B.in, B.out→A.in), DATA_W=6, MSG_WORDS=3, SYNC_STAGES=2, TIMEOUT_CYC=64.
  - A sends 18'h2A5C3 → exactly one B.rx_valid, B.rx_msg=18'h2A5C3. Exactly one A.tx_done. A.tx_ready=1 again. No err pulses.
  - A sends 18'h00FFF and B sends 18'h3F001 simultaneously → both rx_valid, payloads correct and uncorrupted.
- Reset: hold rst=0 for 3 cycles → all outputs 0. Release → tx_ready=1 one edge later.
- Accept at edge T: inter_data_out=word0 at T+1, Request_out=1 at T+2.
- Single instance, Ack_in tied 0, send a message → Request_out falls, tx_timeout pulses 64 cycles after entering T_REQ. tx_ready=1 afterwards.
- Peer completes 2 of 3 words, then goes silent → rx_err pulses after 64 idle cycles, no rx_valid. The next full message is received correctly.
- Assert rst=0 mid-word with Request_out=1 → Request_out=0 next edge, no tx_done or tx_timeout pulse.
